// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared types and constants for the Memory initiator.
//   - state_t       : initiator FSM states
//   - *_DEF         : default bus widths
//   - CS_*/WR_*     : Memory bus encodings (cs is active-low)
package mem_master_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  localparam logic CS_ACTIVE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic WR_WRITE  = 1'b1;
  localparam logic WR_READ   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_master_if.sv
// mem_master_if: client request/data channels plus the Memory bus.
//   master modport : the initiator (drives req_ready, wdata_ready, rdata*,
//                    busy, done and the whole Memory bus; reads mem_o)
//   slave modport  : the client/Memory side (the mirror image)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid must not depend on ready; ready is registered. rdata_valid
// is a one-cycle strobe with no backpressure.
interface mem_master_if
  import mem_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wr;
  logic              mem_cs;
  logic [DATA_W-1:0] mem_o;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wdata, wdata_valid, mem_o,
    output req_ready, wdata_ready, rdata, rdata_valid, busy, done,
           mem_address, mem_data, mem_wr, mem_cs
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wdata, wdata_valid, mem_o,
    input  req_ready, wdata_ready, rdata, rdata_valid, busy, done,
           mem_address, mem_data, mem_wr, mem_cs
  );

endinterface

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: valid shift register tracking reads in flight.
//   i_clk, i_rst_n : clock, async active-low reset (flushes the pipe)
//   i_issue        : a read is put on the bus at this edge
//   o_ret_valid    : the oldest tracked read's data is on mem_o now
//   o_empty        : nothing in flight
module mem_rd_pipe #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_issue,
  output logic o_ret_valid,
  output logic o_empty
);

  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[DEPTH-2:0], i_issue};
    end
  end

  assign o_ret_valid = r_pipe[DEPTH-1];
  assign o_empty     = ~|r_pipe;

endmodule

// File: rtl/mem_master.sv
// mem_master: turns single/burst client requests into Memory bus cycles.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : mem_master_if.master (client channels + Memory bus)
//   o_state        : current FSM state, for debug/checkers
// All outputs are registered from the next-state decode, so each output
// describes the state the FSM is entering on that edge.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LEN_W        = LEN_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_master_if.master  bus,
  output state_t        o_state
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_beats_left;
  logic              r_req_ready;
  logic              r_wdata_ready;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_cs;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_data;

  state_t            w_next_state;
  logic [ADDR_W-1:0] w_cur_addr_nxt;
  logic [LEN_W-1:0]  w_beats_left_nxt;
  logic              w_cs_nxt;
  logic              w_wr_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_issue;
  logic              w_ret_valid;
  logic              w_pipe_empty;

  mem_rd_pipe #(.DEPTH(READ_LATENCY + 1)) u_rd_pipe (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_issue     (w_issue),
    .o_ret_valid (w_ret_valid),
    .o_empty     (w_pipe_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_cur_addr    <= '0;
      r_beats_left  <= '0;
      r_req_ready   <= 1'b1;
      r_wdata_ready <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mem_cs      <= CS_IDLE;
      r_mem_wr      <= WR_READ;
      r_mem_address <= '0;
      r_mem_data    <= '0;
    end else begin
      r_state       <= w_next_state;
      r_cur_addr    <= w_cur_addr_nxt;
      r_beats_left  <= w_beats_left_nxt;
      r_req_ready   <= (w_next_state == ST_IDLE);
      r_wdata_ready <= (w_next_state == ST_WRITE);
      r_busy        <= (w_next_state != ST_IDLE);
      r_done        <= (w_next_state == ST_DONE);
      r_mem_cs      <= w_cs_nxt;
      r_mem_wr      <= w_wr_nxt;
      r_mem_address <= w_addr_nxt;
      r_mem_data    <= w_data_nxt;
      // mem_o carries the oldest in-flight read when the pipe's tail is set
      r_rdata_valid <= w_ret_valid;
      if (w_ret_valid) begin
        r_rdata <= bus.mem_o;
      end
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_cur_addr_nxt   = r_cur_addr;
    w_beats_left_nxt = r_beats_left;
    w_cs_nxt         = CS_IDLE;
    w_wr_nxt         = WR_READ;
    w_addr_nxt       = r_mem_address;
    w_data_nxt       = r_mem_data;
    w_issue          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_cur_addr_nxt   = bus.req_addr;
          w_beats_left_nxt = bus.req_len;
          w_next_state     = bus.req_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        // a cycle without wdata_valid leaves cs idle; the beat count only
        // moves on accepted beats, so gaps never lose or repeat a beat
        if (bus.wdata_valid) begin
          w_cs_nxt         = CS_ACTIVE;
          w_wr_nxt         = WR_WRITE;
          w_addr_nxt       = r_cur_addr;
          w_data_nxt       = bus.wdata;
          w_cur_addr_nxt   = r_cur_addr + ADDR_ONE;
          w_beats_left_nxt = r_beats_left - LEN_ONE;
          if (r_beats_left == '0) begin
            w_next_state = ST_DONE;
          end
        end
      end
      ST_READ: begin
        w_cs_nxt         = CS_ACTIVE;
        w_wr_nxt         = WR_READ;
        w_addr_nxt       = r_cur_addr;
        w_data_nxt       = '0;
        w_issue          = 1'b1;
        w_cur_addr_nxt   = r_cur_addr + ADDR_ONE;
        w_beats_left_nxt = r_beats_left - LEN_ONE;
        if (r_beats_left == '0) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // empty means the last tracked read has already been turned into
        // an rdata_valid strobe, so done cannot overtake it
        if (w_pipe_empty) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.wdata_ready = r_wdata_ready;
  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.mem_cs      = r_mem_cs;
  assign bus.mem_wr      = r_mem_wr;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data    = r_mem_data;
  assign o_state         = r_state;

endmodule
